// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state encoding and default sizing for the PWM capture block
package pwm_cap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

  localparam int CNT_W_DEF       = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_CYC_DEF = 2**20;
  localparam int FILT_LEN_DEF    = 4;

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - control/measurement bundle between a PWM capture block and its user
interface pwm_capture_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             stuck_level;

  modport slave (
    input  enable, pwm_in,
    output period, high_time, meas_valid, timeout, stuck_level
  );

  modport master (
    output enable, pwm_in,
    input  period, high_time, meas_valid, timeout, stuck_level
  );
endinterface

// File: rtl/pwm_capture_in_cond.sv
// rtl/pwm_capture_in_cond.sv - pwm_in synchronizer, optional glitch filter (PWM_CAP_FILTER_EN), edge detect
module pwm_in_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   cond;
  logic                   prev_q;

  // multi-flop synchronizer; pwm_in enters at bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_FILTER_EN
  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic [FW-1:0] filt_cnt;
  logic          filt_q;

  // filtered level flips only after FILT_LEN consecutive samples disagree with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q   <= 1'b0;
      filt_cnt <= '0;
    end else if (synced == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      filt_q   <= synced;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign cond = filt_q;
`else
  logic unused_filt_len;
  assign unused_filt_len = (FILT_LEN > 0);
  assign cond = synced;
`endif

  // previous conditioned level for single-cycle edge pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= cond;
  end

  assign level = cond;
  assign rise  = cond & ~prev_q;
  assign fall  = ~cond & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with edge-loss timeout; PWM_CAP_FILTER_EN adds a glitch filter
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic          clk,
  input  logic          reset,
  pwm_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

  logic             level;
  logic             rise;
  logic             fall;
  cap_state_t       state;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] hi_lat;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             timeout_q;
  logic             stuck_q;
  logic             sat;

  pwm_in_cond #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_cond (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (bus.pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign sat = (run_cnt == TMO);

  // cycles since the last rise; restarts at 1 on a rise and parks at the timeout value
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            run_cnt <= '0;
    else if (!bus.enable) run_cnt <= '0;
    else if (rise)        run_cnt <= CNT_W'(1);
    else if (!sat)        run_cnt <= run_cnt + CNT_W'(1);
  end

  // arm on the first rise, latch high time on fall, publish on the following rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hi_lat    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!bus.enable) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) state <= HIGH;
          end
          HIGH: begin
            if (sat) begin
              state     <= IDLE;
              timeout_q <= 1'b1;
              stuck_q   <= level;
            end else if (fall) begin
              state  <= LOW;
              hi_lat <= run_cnt;
            end
          end
          LOW: begin
            // a rise landing on the saturation cycle still counts as a period
            if (rise) begin
              state     <= HIGH;
              period_q  <= run_cnt;
              high_q    <= hi_lat;
              valid_q   <= 1'b1;
              timeout_q <= 1'b0;
            end else if (sat) begin
              state     <= IDLE;
              timeout_q <= 1'b1;
              stuck_q   <= level;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period      = period_q;
  assign bus.high_time   = high_q;
  assign bus.meas_valid  = valid_q;
  assign bus.timeout     = timeout_q;
  assign bus.stuck_level = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture (expectations follow PWM_CAP_FILTER_EN)
module tb_pwm_capture;

  localparam int CW = 16;
  localparam int SS = 2;
  localparam int TC = 16;
  localparam int FL = 3;
`ifdef PWM_CAP_FILTER_EN
  localparam bit FON = 1'b1;
`else
  localparam bit FON = 1'b0;
`endif

  typedef struct packed {
    logic [CW-1:0] p;
    logic [CW-1:0] h;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  exp_t mon_e;
  int   total  = 0;
  int   bad    = 0;
  int   n_push = 0;
  int   n_seen = 0;
  int   lat;

  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_W(CW)) bus ();

  pwm_capture #(
    .CNT_W       (CW),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TC),
    .FILT_LEN    (FL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input int p, input int h);
    exp_q.push_back({CW'(p), CW'(h)});
    n_push++;
  endtask

  // n periods of h high / l low, then a closing rise held 4 cycles and 6 low cycles
  task automatic train(input int h, input int l, input int n, input bit meas);
    for (int i = 0; i < n; i++) begin
      bus.pwm_in = 1'b1;
      cyc(h);
      bus.pwm_in = 1'b0;
      cyc(l);
      if (meas) push(h + l, h);
    end
    bus.pwm_in = 1'b1;
    cyc(4);
    bus.pwm_in = 1'b0;
    cyc(6);
  endtask

  task automatic rearm();
    bus.enable = 1'b0;
    cyc(2);
    bus.enable = 1'b1;
    cyc(2);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.meas_valid === 1'b1) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got period=%0d high_time=%0d, required no strobe",
                 bus.period, bus.high_time);
      end else begin
        mon_e = exp_q.pop_front();
        check("period", 32'(bus.period), 32'(mon_e.p));
        check("high_time", 32'(bus.high_time), 32'(mon_e.h));
        check("timeout_clear", 32'(bus.timeout), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    cyc(3);
    check("rst_period", 32'(bus.period), 32'd0);
    check("rst_high_time", 32'(bus.high_time), 32'd0);
    check("rst_valid", 32'(bus.meas_valid), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_stuck", 32'(bus.stuck_level), 32'd0);
    reset = 1'b0;
    bus.enable = 1'b1;
    cyc(4);

    // H=3,L=5
    train(3, 5, 4, 1'b1);
    rearm();

    // H=1,L=1; the filter swallows single-cycle pulses
    train(1, 1, 6, !FON);
    rearm();
    check("hold_period", 32'(bus.period), FON ? 32'd8 : 32'd2);
    check("hold_high_time", 32'(bus.high_time), FON ? 32'd3 : 32'd1);

    // stuck high after arming
    bus.pwm_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc(1);
      if (bus.timeout === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("timeout_latency", 32'(lat), 32'(SS + 1 + TC + (FON ? FL : 0)));
    check("timeout_set", 32'(bus.timeout), 32'd1);
    check("stuck_level", 32'(bus.stuck_level), 32'd1);
    check("timeout_hold_period", 32'(bus.period), FON ? 32'd8 : 32'd2);
    bus.pwm_in = 1'b0;
    cyc(4);
    train(4, 4, 1, 1'b1);
    check("timeout_cleared", 32'(bus.timeout), 32'd0);
    rearm();

    // reset in the middle of a high phase
    bus.pwm_in = 1'b1;
    cyc(8);
    reset = 1'b1;
    #1;
    check("midrst_period", 32'(bus.period), 32'd0);
    check("midrst_high_time", 32'(bus.high_time), 32'd0);
    check("midrst_valid", 32'(bus.meas_valid), 32'd0);
    check("midrst_timeout", 32'(bus.timeout), 32'd0);
    check("midrst_stuck", 32'(bus.stuck_level), 32'd0);
    cyc(2);
    bus.pwm_in = 1'b0;
    cyc(1);
    reset = 1'b0;
    cyc(3);
    train(3, 3, 1, 1'b1);
    rearm();

    // enable dropped while in LOW, pulses while disabled are ignored
    train(3, 5, 1, 1'b1);
    bus.enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.pwm_in = 1'b1;
      cyc(2);
      bus.pwm_in = 1'b0;
      cyc(2);
    end
    cyc(6);
    check("dis_hold_period", 32'(bus.period), 32'd8);
    check("dis_hold_high_time", 32'(bus.high_time), 32'd3);
    check("dis_valid", 32'(bus.meas_valid), 32'd0);
    bus.enable = 1'b1;
    cyc(2);
    train(2, 6, 2, !FON);
    rearm();

    // 2-cycle low glitch inside a 10-cycle high phase
    bus.pwm_in = 1'b1;
    cyc(4);
    bus.pwm_in = 1'b0;
    cyc(2);
    if (!FON) push(6, 4);
    bus.pwm_in = 1'b1;
    cyc(4);
    bus.pwm_in = 1'b0;
    cyc(10);
    if (FON) push(20, 10);
    else     push(14, 4);
    bus.pwm_in = 1'b1;
    cyc(4);
    bus.pwm_in = 1'b0;
    cyc(6);
    bus.enable = 1'b0;

    cyc(10);
    check("drain", 32'(exp_q.size()), 32'd0);
    check("strobe_count", 32'(n_seen), 32'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
